// File: rtl/addx_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : addx_seq_pkg
// Brief  : Shared constants for the addx_seq modular add/sub sequencer.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package addx_seq_pkg;

  localparam int LANES        = 4;
  localparam int DRAIN_CYCLES = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addx_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : addx_lane
// Brief  : Two-stage modular add/subtract for a single lane (operands < q).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module addx_lane #(
  parameter int MODULUS_WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ld1,
  input  logic                     i_ld2,
  input  logic [MODULUS_WIDTH-1:0] i_a,
  input  logic [MODULUS_WIDTH-1:0] i_b,
  input  logic [MODULUS_WIDTH-1:0] i_q,
  input  logic                     i_neg,
  output logic [MODULUS_WIDTH-1:0] o_r
);

  logic [MODULUS_WIDTH:0] r_sum;
  logic [MODULUS_WIDTH:0] r_dif;
  logic                   r_neg;
  logic [MODULUS_WIDTH:0] w_qx;
  logic [MODULUS_WIDTH:0] w_sel;

  assign w_qx  = {1'b0, i_q};
  assign w_sel = r_neg ? r_dif : r_sum;

  // a+q-b stays in (0, 2q) for in-range operands, so one conditional subtract suffices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_dif <= '0;
      r_neg <= 1'b0;
      o_r   <= '0;
    end else begin
      if (i_ld1) begin
        r_sum <= {1'b0, i_a} + {1'b0, i_b};
        r_dif <= {1'b0, i_a} + w_qx - {1'b0, i_b};
        r_neg <= i_neg;
      end
      if (i_ld2) begin
        o_r <= (w_sel >= w_qx) ? (w_sel[MODULUS_WIDTH-1:0] - i_q) : w_sel[MODULUS_WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/addx_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : addx_seq
// Brief  : Per-lane modular add/sub of o1/o2 groups, sequential C1 URAM writes.
//          Optional operand range check enabled by ADDX_RANGE_CHECK_EN.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module addx_seq
  import addx_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MODULUS_WIDTH = 35,
  parameter int ADDR_WIDTH    = 12,
  parameter int NUM_BEATS     = 2048
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic                          i_start,
  input  logic [MODULUS_WIDTH-1:0]      i_modulus,
  input  logic [3:0]                    i_n,
  input  logic [LANES*DATA_WIDTH-1:0]   i_data_o1,
  input  logic [LANES*DATA_WIDTH-1:0]   i_data_o2,
  input  logic                          i_valid,
  input  logic                          i_negate,
  output logic [LANES*DATA_WIDTH-1:0]   o_data_c1,
  output logic [ADDR_WIDTH-1:0]         o_addr_c1,
  output logic                          o_we_c1,
  output logic [3:0]                    o_n_c1,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int                    DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(NUM_BEATS - 1);
  localparam logic [DRAIN_W-1:0]    C_DEND  = DRAIN_W'(DRAIN_CYCLES - 1);

  logic [1:0]               r_state;
  logic [ADDR_WIDTH-1:0]    r_beat;
  logic [ADDR_WIDTH-1:0]    r_addr1;
  logic [DRAIN_W-1:0]       r_drain;
  logic                     r_v1;
  logic                     r_last1;
  logic                     w_accept;
  logic                     w_ld2;
  logic [MODULUS_WIDTH-1:0] w_r [LANES];
  logic                     w_unused_hi;

  assign w_accept = i_en & ~i_start & i_valid & (r_state == ST_RUN);
  assign w_ld2    = i_en & ~i_start & r_v1;
  assign o_busy   = (r_state != ST_IDLE);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int LSB = lane_lsb(k, DATA_WIDTH);
    addx_lane #(.MODULUS_WIDTH(MODULUS_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_ld1 (w_accept),
      .i_ld2 (w_ld2),
      .i_a   (i_data_o1[LSB +: MODULUS_WIDTH]),
      .i_b   (i_data_o2[LSB +: MODULUS_WIDTH]),
      .i_q   (i_modulus),
      .i_neg (i_negate),
      .o_r   (w_r[k])
    );
  end

  always_comb begin
    o_data_c1   = '0;
    w_unused_hi = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      o_data_c1[k*DATA_WIDTH +: MODULUS_WIDTH] = w_r[k];
      w_unused_hi = w_unused_hi
                  ^ (^i_data_o1[k*DATA_WIDTH+MODULUS_WIDTH +: DATA_WIDTH-MODULUS_WIDTH])
                  ^ (^i_data_o2[k*DATA_WIDTH+MODULUS_WIDTH +: DATA_WIDTH-MODULUS_WIDTH]);
    end
  end

`ifdef ADDX_RANGE_CHECK_EN
  logic w_oor;
  always_comb begin
    w_oor = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if ((i_data_o1[k*DATA_WIDTH +: MODULUS_WIDTH] >= i_modulus) ||
          (i_data_o2[k*DATA_WIDTH +: MODULUS_WIDTH] >= i_modulus)) begin
        w_oor = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_addr1   <= '0;
      r_drain   <= '0;
      r_v1      <= 1'b0;
      r_last1   <= 1'b0;
      o_addr_c1 <= '0;
      o_we_c1   <= 1'b0;
      o_n_c1    <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else if (!i_en) begin
      r_state <= ST_IDLE;
      r_v1    <= 1'b0;
      o_we_c1 <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      // a start squashes both in-flight slots: r_v1 and the write it would produce
      r_v1    <= w_accept;
      r_last1 <= w_accept & (r_beat == C_LAST);
      o_we_c1 <= w_ld2;
      o_done  <= w_ld2 & r_last1;
      if (w_ld2) begin
        o_addr_c1 <= r_addr1;
      end
      if (w_accept) begin
        r_addr1 <= r_beat;
        r_beat  <= r_beat + 1'b1;
      end
      if (i_start) begin
        r_state <= ST_RUN;
        r_beat  <= '0;
        r_drain <= '0;
        o_n_c1  <= i_n;
        if (r_state == ST_IDLE) begin
          o_err <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_valid) o_err <= 1'b1;
          end
          ST_RUN: begin
            if (w_accept && (r_beat == C_LAST)) begin
              r_state <= ST_DRAIN;
              r_drain <= '0;
            end
          end
          ST_DRAIN: begin
            if (i_valid) o_err <= 1'b1;
            if (r_drain == C_DEND) r_state <= ST_IDLE;
            else                   r_drain <= r_drain + DRAIN_W'(1);
          end
          default: r_state <= ST_IDLE;
        endcase
      end
`ifdef ADDX_RANGE_CHECK_EN
      if (w_accept && w_oor) o_err <= 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addx_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_addx_seq
// Brief  : Directed self-checking bench for addx_seq (default and 16-beat builds).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_addx_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         en16 = 1'b0;
  logic         start = 1'b0;
  logic [34:0]  q = 35'd97;
  logic [3:0]   n = 4'd0;
  logic [255:0] o1 = '0;
  logic [255:0] o2 = '0;
  logic         valid = 1'b0;
  logic         neg = 1'b0;

  logic [255:0] data;
  logic [11:0]  addr;
  logic         we, busy, done, err;
  logic [3:0]   n_c1;
  logic [255:0] data16;
  logic [11:0]  addr16;
  logic         we16, busy16, done16, err16;
  logic [3:0]   n16;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addx_seq u_dut (
    .clk(clk), .rst(rst), .i_en(en), .i_start(start), .i_modulus(q), .i_n(n),
    .i_data_o1(o1), .i_data_o2(o2), .i_valid(valid), .i_negate(neg),
    .o_data_c1(data), .o_addr_c1(addr), .o_we_c1(we), .o_n_c1(n_c1),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  addx_seq #(.NUM_BEATS(16)) u_dut16 (
    .clk(clk), .rst(rst), .i_en(en16), .i_start(start), .i_modulus(q), .i_n(n),
    .i_data_o1(o1), .i_data_o2(o2), .i_valid(valid), .i_negate(neg),
    .o_data_c1(data16), .o_addr_c1(addr16), .o_we_c1(we16), .o_n_c1(n16),
    .o_busy(busy16), .o_done(done16), .o_err(err16)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] lanes(input logic [34:0] v3, v2, v1, v0);
    return {29'd0, v3, 29'd0, v2, 29'd0, v1, 29'd0, v0};
  endfunction

  function automatic logic [255:0] rep(input logic [34:0] v);
    return lanes(v, v, v, v);
  endfunction

  // drive one beat, then check it lands two edges later
  task automatic send_chk(input string tag, input logic [255:0] a, input logic [255:0] b,
                          input logic ng, input logic [255:0] exp, input logic [11:0] exp_addr);
    @(negedge clk);
    o1 = a; o2 = b; neg = ng; valid = 1'b1;
    tick();
    chk({tag, "_lat_we"}, we, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    tick();
    chk({tag, "_we"}, we, 1'b1);
    chk({tag, "_data"}, data, exp);
    chk({tag, "_addr"}, addr, exp_addr);
  endtask

  initial begin
    int nw;
    int nd;
    #1;
    chk("rst_data", data, '0);
    chk("rst_addr", addr, 0);
    chk("rst_we", we, 0);
    chk("rst_n", n_c1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    @(negedge clk); rst = 1'b0;
    @(negedge clk); en = 1'b1; valid = 1'b1;
    tick();
    chk("idle_err", err, 1);
    chk("idle_we", we, 0);
    @(negedge clk); valid = 1'b0; start = 1'b1; n = 4'd5;
    tick();
    chk("start_busy", busy, 1);
    chk("start_errclr", err, 0);
    chk("start_n", n_c1, 5);
    chk("idle_nowrite", we, 0);
    @(negedge clk); start = 1'b0;

    send_chk("add",    rep(10), rep(20), 1'b0, rep(30), 12'd0);
    send_chk("addred", rep(90), rep(20), 1'b0, rep(13), 12'd1);
    send_chk("sub",    rep(5),  rep(20), 1'b1, rep(82), 12'd2);
    send_chk("subeq",  rep(96), rep(96), 1'b1, rep(0),  12'd3);
    send_chk("mixadd", lanes(96, 0, 50, 1), lanes(1, 0, 60, 96), 1'b0, lanes(0, 0, 13, 0), 12'd4);
    send_chk("mixsub", lanes(96, 0, 50, 1), lanes(1, 0, 60, 96), 1'b1, lanes(95, 0, 87, 2), 12'd5);
    send_chk("aeqq",   rep(97), rep(0),  1'b0, rep(0),  12'd6);
`ifdef ADDX_RANGE_CHECK_EN
    chk("range_err", err, 1);
`else
    chk("range_err", err, 0);
`endif

    @(negedge clk); en = 1'b0;
    tick();
    chk("dis_busy", busy, 0);
    chk("dis_addr_hold", addr, 6);
    chk("dis_n_hold", n_c1, 5);

    // full pass
    @(negedge clk); en = 1'b1; start = 1'b1; n = 4'd3;
    tick();
    chk("pass_errclr", err, 0);
    for (int i = 0; i < 2050; i++) begin
      @(negedge clk);
      start = 1'b0; valid = (i < 2048); o1 = rep(1); o2 = rep(2); neg = 1'b0;
      tick();
      if (i == 0) chk("pass_we0", we, 0);
      if (i >= 1 && i <= 2048) begin
        chk("pass_we", we, 1);
        chk("pass_addr", addr, 12'(i - 1));
        chk("pass_done", done, (i == 2048));
      end
      if (i == 2048) begin
        chk("pass_busy_last", busy, 1);
        chk("pass_n", n_c1, 3);
      end
      if (i == 2049) begin
        chk("pass_busy_fall", busy, 0);
        chk("pass_we_end", we, 0);
        chk("pass_done_end", done, 0);
      end
    end
    chk("pass_data", data, rep(3));
    chk("pass_err", err, 0);

    // restart with beats in flight
    @(negedge clk); start = 1'b1; n = 4'd2; valid = 1'b0;
    tick();
    for (int i = 0; i < 103; i++) begin
      @(negedge clk);
      start = (i == 100); n = (i == 100) ? 4'd7 : 4'd2; valid = 1'b1;
      o1 = (i <= 100) ? rep(3) : rep(10);
      o2 = (i <= 100) ? rep(4) : rep(5);
      neg = (i > 100);
      tick();
      if (i == 99) begin
        chk("rs_pre_we", we, 1);
        chk("rs_pre_addr", addr, 98);
      end
      if (i == 100) begin
        chk("rs_squash1", we, 0);
        chk("rs_n", n_c1, 7);
      end
      if (i == 101) chk("rs_squash2", we, 0);
      if (i == 102) begin
        chk("rs_we", we, 1);
        chk("rs_addr", addr, 0);
        chk("rs_data", data, rep(5));
      end
    end

    // reset mid-pass
    @(negedge clk); valid = 1'b0; rst = 1'b1;
    #1;
    chk("mrst_we", we, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_data", data, '0);
    chk("mrst_n", n_c1, 0);
    tick();
    chk("mrst_nowrite", we, 0);
    @(negedge clk); rst = 1'b0; en = 1'b0;

    // gapped 16-beat pass on the small instance
    @(negedge clk); en16 = 1'b1; start = 1'b1; n = 4'd9;
    tick();
    chk("gap_busy", busy16, 1);
    chk("gap_err0", err16, 0);
    nw = 0;
    nd = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      start = 1'b0; valid = (i < 32) && (i % 2 == 0); o1 = rep(1); o2 = rep(2); neg = 1'b0;
      tick();
      if (we16) begin
        chk("gap_addr", addr16, 12'(nw));
        nw++;
      end
      if (done16) begin
        chk("gap_done_addr", addr16, 15);
        nd++;
      end
    end
    chk("gap_writes", nw, 16);
    chk("gap_dones", nd, 1);
    chk("gap_err", err16, 0);
    chk("gap_busy_end", busy16, 0);
    chk("gap_data", data16, rep(3));
    chk("gap_n", n16, 9);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
